sevenseg_mux_ctrl: RTL and testbench
====================================

Name: sevenseg_mux_ctrl

Overview:
Time-multiplexing scheduler that shares one hex-to-seven-segment decoder among NUM_DIGITS common-anode digits. It cycles through the digits, presenting each digit's nibble to the shared decoder input while enabling that digit's anode. Between digits it inserts an all-off blanking interval to suppress ghosting. It sits between the digit-value sources and the single decoder/anode drivers in the dual-display top level.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (>=2)
REFRESH_CYCLES, 12000, clk cycles each digit is lit (>=1)
BLANK_CYCLES, 480, clk cycles of all-anodes-off before each digit (>=1)

Ports:
clk  input  1  system clock; all logic rising-edge
reset  input  1  synchronous, active-high reset
en  input  1  scan enable; low forces blank and restarts the scan
digits_in  input  NUM_DIGITS*4  digit i nibble at [4i+3:4i]
lut_s  output  4  nibble to shared decoder input (registered)
an_n  output  NUM_DIGITS  active-low anode enables (registered); bit i = digit i
digit_idx  output  $clog2(NUM_DIGITS)  index of current/next digit (registered)
frame_done  output  1  one-cycle pulse when the last digit's SHOW ends

Behaviour:
- Reset (sync, highest priority): state=BLANK, cnt=0, digit_idx=0, an_n=all 1, lut_s=4'h0, frame_done=0.
- States:
  - BLANK: an_n all 1. cnt counts 0..BLANK_CYCLES-1. On the edge where cnt==BLANK_CYCLES-1 (and en=1): state<=SHOW, cnt<=0, lut_s<=digits_in[digit_idx], an_n[digit_idx]<=0, others 1.
  - SHOW: cnt counts 0..REFRESH_CYCLES-1; lut_s and an_n held. On the edge where cnt==REFRESH_CYCLES-1: state<=BLANK, cnt<=0, an_n<=all 1, digit_idx<=digit_idx+1 with wrap NUM_DIGITS-1 -> 0.
  - frame_done<=1 on that edge only when digit_idx was NUM_DIGITS-1; otherwise 0.
- Timing from the first edge with reset=0 and en=1 (edge 0):
  - Digit 0 anode is low for cycles B..B+R-1.
  - Digit 1 anode is low for cycles 2B+R..2B+2R-1.
  - Frame period is NUM_DIGITS*(B+R) cycles (B=BLANK_CYCLES, R=REFRESH_CYCLES).
- Capture: digits_in is sampled only on the BLANK->SHOW edge. Changes during SHOW do not affect lut_s until that digit's next SHOW.
- lut_s is not cleared in BLANK; it holds its last value. Anodes are off, so nothing is displayed.
- en=0 on any edge (reset=0): state<=BLANK, cnt<=0, digit_idx<=0, an_n<=all 1, frame_done<=0, lut_s holds.
  - This applies mid-SHOW too: anodes go off the cycle after en falls.
  - When en returns high, a full BLANK interval precedes digit 0.
- No two anode bits are ever low simultaneously. Every anode transition passes through at least BLANK_CYCLES of all-off.
- Counter width: $clog2(max(REFRESH_CYCLES,BLANK_CYCLES)). The counter never exceeds its terminal value.
- Elaboration-time assertions: NUM_DIGITS>=2, REFRESH_CYCLES>=1, BLANK_CYCLES>=1.
- The block does not instantiate the decoder. The top level connects lut_s to the decoder's nibble input and an_n to the anode drivers.

Decomposition:
- Package sevenseg_pkg:
  - NIBBLE_W=4
  - ANODES_OFF (all-ones pattern function/constant by NUM_DIGITS)
  - state enum scan_state_t {BLANK, SHOW}
- One natural sub-module: phase_timer.
  - Parameterised terminal count; clear and run inputs; done output high on the terminal cycle.
  - Used once, with the terminal value muxed by state, or as two instances, B and R.
- All remaining logic (FSM, index, capture, outputs) stays in sevenseg_mux_ctrl.

Test Plan (bench params NUM_DIGITS=2, REFRESH_CYCLES=4, BLANK_CYCLES=2):
1. Hold reset 3 cycles with digits_in=8'hA5 -> an_n=2'b11, lut_s=0, digit_idx=0, frame_done=0 on every cycle during reset.
2. Release reset, en=1, digits_in=8'hA5 -> an_n=11 for cycles 0-1; an_n=10 and lut_s=5 for cycles 2-5; an_n=11 for cycles 6-7; an_n=01 and lut_s=A for cycles 8-11; frame_done high exactly at cycle 12; pattern repeats every 12 cycles.
3. Change digits_in to 8'h3C at cycle 3 (mid digit-0 SHOW) -> lut_s stays 5 through cycle 5; digit 1 shows 3 at cycles 8-11; digit 0 shows C from cycle 14.
4. Drop en at cycle 9 (digit-1 SHOW), raise at cycle 12 -> an_n=11 from cycle 10; digit_idx=0; no frame_done; digit 0 lit again at cycles 14-17.
5. Assert reset for 1 cycle mid-SHOW -> next cycle all outputs equal reset values; scan restarts with timing identical to scenario 2.
6. Run 100 frames with random digits_in and random en -> assertion never sees more than one an_n bit low, and every anode change has at least BLANK_CYCLES all-off cycles between it and the next.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Provides nibble width, the all-anodes-off pattern, scan states and sizing.
package sevenseg_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 32;

    // Common-anode drivers are active low, so "off" is all ones.
    // Users slice the low NUM_DIGITS bits.
    localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Width of a counter that must reach max(a,b)-1; never below 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Free-running phase counter that wraps at a supplied terminal value.
// Ports: clk, reset (sync, high), i_clear, i_run, i_term, o_done.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_run,
    input  logic [W-1:0] i_term,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    assign o_done = (r_cnt == i_term);

    // Wrapping on done means the next phase always starts at zero,
    // so the counter never exceeds the terminal value in force.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_done ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sevenseg_mux_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one decoder,
// with an all-off blanking gap before every digit to suppress ghosting.
// Ports: clk, reset (sync, high), en (scan enable), digits_in (packed nibbles),
//        lut_s (decoder nibble), an_n (active-low anodes), digit_idx, frame_done.
module sevenseg_mux_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int REFRESH_CYCLES = 12000,
    parameter int BLANK_CYCLES   = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_DIGITS*4-1:0]       digits_in,
    output logic [3:0]                    lut_s,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = cnt_width(REFRESH_CYCLES, BLANK_CYCLES);

    localparam logic [NUM_DIGITS-1:0] AN_OFF   = ANODES_OFF[NUM_DIGITS-1:0];
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      R_TERM   = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0]      B_TERM   = CNT_W'(BLANK_CYCLES - 1);

    if (NUM_DIGITS < 2) begin : g_chk_digits
        $error("NUM_DIGITS must be >= 2");
    end
    if (NUM_DIGITS > MAX_DIGITS) begin : g_chk_max
        $error("NUM_DIGITS exceeds MAX_DIGITS");
    end
    if (REFRESH_CYCLES < 1) begin : g_chk_refresh
        $error("REFRESH_CYCLES must be >= 1");
    end
    if (BLANK_CYCLES < 1) begin : g_chk_blank
        $error("BLANK_CYCLES must be >= 1");
    end

    scan_state_t           r_state;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [NIBBLE_W-1:0]   r_lut_s;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic                  r_frame_done;

    logic                  w_done;
    logic [CNT_W-1:0]      w_term;
    logic [NIBBLE_W-1:0]   w_nib;
    logic [NUM_DIGITS-1:0] w_an_sel;
    logic [IDX_W-1:0]      w_idx_next;
    logic [NIBBLE_W-1:0]   w_nibs [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign w_nibs[g] = digits_in[g*NIBBLE_W +: NIBBLE_W];
    end

    assign w_nib      = w_nibs[r_digit_idx];
    assign w_an_sel   = ~(NUM_DIGITS'(1) << r_digit_idx);
    assign w_idx_next = (r_digit_idx == LAST_IDX) ? '0 : r_digit_idx + 1'b1;

    // One shared timer; its terminal value follows the current phase.
    assign w_term = (r_state == SHOW) ? R_TERM : B_TERM;

    phase_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (~en),
        .i_run   (en),
        .i_term  (w_term),
        .o_done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= BLANK;
            r_digit_idx  <= '0;
            r_an_n       <= AN_OFF;
            r_lut_s      <= '0;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            // Restart the scan; lut_s keeps its value, anodes are dark.
            r_state      <= BLANK;
            r_digit_idx  <= '0;
            r_an_n       <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                BLANK: begin
                    if (w_done) begin
                        r_state <= SHOW;
                        r_lut_s <= w_nib;
                        r_an_n  <= w_an_sel;
                    end
                end
                SHOW: begin
                    if (w_done) begin
                        r_state      <= BLANK;
                        r_an_n       <= AN_OFF;
                        r_digit_idx  <= w_idx_next;
                        r_frame_done <= (r_digit_idx == LAST_IDX);
                    end
                end
            endcase
        end
    end

    assign lut_s      = r_lut_s;
    assign an_n       = r_an_n;
    assign digit_idx  = r_digit_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sevenseg_mux_ctrl.sv
// Scoreboard bench for sevenseg_mux_ctrl with N=2, R=4, B=2.
// Expected outputs come from a frame-position model of the scan timing.
module tb_sevenseg_mux_ctrl;

    localparam int N = 2;
    localparam int R = 4;
    localparam int B = 2;
    localparam int F = N * (B + R);

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] digits_in;
    logic [3:0] lut_s;
    logic [1:0] an_n;
    logic [0:0] digit_idx;
    logic       frame_done;

    always #5 clk = ~clk;

    sevenseg_mux_ctrl #(
        .NUM_DIGITS     (N),
        .REFRESH_CYCLES (R),
        .BLANK_CYCLES   (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digits_in  (digits_in),
        .lut_s      (lut_s),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [1:0] an;
        logic [3:0] lut;
        logic       idx;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: m_q = enabled edges since scan (re)start, modulo the frame.
    int         m_q   = 0;
    logic [3:0] m_lut = 4'h0;
    logic       m_fd  = 1'b0;

    // Drive one cycle of inputs, push the expected result, advance a cycle.
    task automatic drive(input logic r, input logic e, input logic [7:0] d);
        obs_t x;
        int   blk;
        int   pos;
        reset     = r;
        en        = e;
        digits_in = d;
        if (r) begin
            m_q   = 0;
            m_lut = 4'h0;
            m_fd  = 1'b0;
        end else if (!e) begin
            m_q  = 0;
            m_fd = 1'b0;
        end else begin
            m_q  = (m_q + 1) % F;
            m_fd = (m_q == 0);
            blk  = m_q / (B + R);
            pos  = m_q % (B + R);
            if (pos == B) m_lut = d[4*blk +: 4];
        end
        blk   = m_q / (B + R);
        pos   = m_q % (B + R);
        x.an  = (pos >= B) ? ~(2'b01 << blk) : 2'b11;
        x.lut = m_lut;
        x.idx = blk[0];
        x.fd  = m_fd;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t got, ex;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 8'hA5);
            got = {an_n, lut_s, digit_idx, frame_done};
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL reset cyc %0d got an/lut/idx/fd=%b exp=%b",
                         k, got, ex);
            end
        end
    endtask

    task automatic test_scan();
        obs_t got, ex;
        for (int k = 0; k < 3 * F; k++) begin
            drive(1'b0, 1'b1, 8'hA5);
            got = {an_n, lut_s, digit_idx, frame_done};
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL scan cyc %0d got an/lut/idx/fd=%b exp=%b",
                         k + 1, got, ex);
            end
        end
    endtask

    task automatic test_capture();
        obs_t got, ex;
        drive(1'b1, 1'b0, 8'hA5);
        void'(exp_q.pop_front());
        for (int k = 0; k < 2 * F; k++) begin
            drive(1'b0, 1'b1, (k >= 3) ? 8'h3C : 8'hA5);
            got = {an_n, lut_s, digit_idx, frame_done};
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL capture cyc %0d got an/lut/idx/fd=%b exp=%b",
                         k + 1, got, ex);
            end
        end
    endtask

    task automatic test_enable();
        obs_t got, ex;
        drive(1'b1, 1'b0, 8'hA5);
        void'(exp_q.pop_front());
        for (int k = 0; k < 26; k++) begin
            drive(1'b0, !(k >= 9 && k <= 11), 8'hA5);
            got = {an_n, lut_s, digit_idx, frame_done};
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL enable cyc %0d got an/lut/idx/fd=%b exp=%b",
                         k + 1, got, ex);
            end
        end
    endtask

    task automatic test_midshow_reset();
        obs_t got, ex;
        drive(1'b1, 1'b0, 8'h5A);
        void'(exp_q.pop_front());
        for (int k = 0; k < 4 + 1 + 2 * F; k++) begin
            drive(k == 4, 1'b1, 8'h5A);
            got = {an_n, lut_s, digit_idx, frame_done};
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL midreset cyc %0d got an/lut/idx/fd=%b exp=%b",
                         k + 1, got, ex);
            end
        end
    endtask

    task automatic test_random();
        obs_t       got, ex;
        logic [1:0] prev_an;
        int         off_run;
        drive(1'b1, 1'b0, 8'h00);
        void'(exp_q.pop_front());
        prev_an = an_n;
        off_run = 1;
        for (int k = 0; k < 100 * F; k++) begin
            drive(1'b0, $urandom_range(0, 19) != 0, 8'($urandom));
            got = {an_n, lut_s, digit_idx, frame_done};
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL random cyc %0d got an/lut/idx/fd=%b exp=%b",
                         k, got, ex);
            end
            checks++;
            if ($countones(~an_n) > 1) begin
                errors++;
                $display("FAIL onehot cyc %0d an_n=%b exp at most one low",
                         k, an_n);
            end
            if (an_n != 2'b11 && an_n != prev_an) begin
                checks++;
                if (prev_an != 2'b11 || off_run < B) begin
                    errors++;
                    $display("FAIL gap cyc %0d off_run=%0d prev=%b exp >= %0d",
                             k, off_run, prev_an, B);
                end
            end
            off_run = (an_n == 2'b11) ? off_run + 1 : 0;
            prev_an = an_n;
        end
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        digits_in = 8'h00;
        test_reset();
        test_scan();
        test_capture();
        test_enable();
        test_midshow_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
